mc_control_fsm: RTL and testbench

Multicycle control unit for the ARM-subset processor. It sequences the shared-memory datapath through fetch, decode, execute, memory and writeback states and decodes the ALU operation. It holds the NZCV flag register and the latched condition result, and gates every architectural write (PC, register file, memory, flags) with that condition. It sits between the instruction register and the datapath mux/enable inputs and drives all of them.

---
 rtl/mc_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the ARM-subset processor: sequences fetch/decode/execute,
// decodes the ALU operation, holds NZCV and the latched condition, and gates all writes.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags;
  logic       condex_q;
  logic       cond_ex;
  logic       ir_w, next_pc, branch, reg_w, mem_w, alu_op, no_write;
  logic [1:0] flag_w;
  logic [3:0] cmd;
  logic       s_bit;
  logic       n, z, c, v;

  assign cmd          = Funct[4:1];
  assign s_bit        = Funct[0];
  assign {n, z, c, v} = flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    ir_w      = 1'b0;
    next_pc   = 1'b0;
    branch    = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    alu_op    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_op  = 1'b1;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU decode; flag-setting arithmetic ops also update C and V
  always_comb begin
    ALUControl = 2'b00;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (cmd)
        4'b0100: begin ALUControl = 2'b00; flag_w = {s_bit, s_bit}; end
        4'b0010: begin ALUControl = 2'b01; flag_w = {s_bit, s_bit}; end
        4'b0000: begin ALUControl = 2'b10; flag_w = {s_bit, 1'b0};  end
        4'b1100: begin ALUControl = 2'b11; flag_w = {s_bit, 1'b0};  end
        4'b1010: begin ALUControl = 2'b01; flag_w = {s_bit, s_bit}; end
        default: begin ALUControl = 2'b00; flag_w = 2'b00;          end
      endcase
    end
  end

  // CMP never writes back, so suppression is keyed on the instruction, not on ALUOp
  assign no_write = (Op == 2'b00) && (cmd == 4'b1010);

  always_comb begin
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      condex_q <= 1'b0;
      flags    <= 4'b0000;
    end else begin
      if (state_q == S_DECODE) condex_q <= cond_ex;
      if (flag_w[1] && condex_q) flags[3:2] <= ALUFlags[3:2];
      if (flag_w[0] && condex_q) flags[1:0] <= ALUFlags[1:0];
    end
  end

  assign PCWrite  = reset & (next_pc | (branch & condex_q));
  assign MemWrite = reset & mem_w & condex_q;
  assign RegWrite = reset & reg_w & condex_q & ~no_write;
  assign IRWrite  = reset & ir_w;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign state    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-instruction expected cycle traces are queued
// by the stimulus process and checked cycle by cycle by an independent monitor.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] ALUFlags;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] state;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, memw, regw, irw, adr;
    logic [1:0] srca, srcb, res, aluc, imm, rsrc;
    logic [3:0] flg;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  logic [3:0] m_flags;
  event       chk_ev;

  function automatic exp_t rec(input logic [3:0] st, input logic pcw, input logic memw,
                               input logic regw, input logic irw, input logic adr,
                               input logic [1:0] srca, input logic [1:0] srcb,
                               input logic [1:0] res, input logic [1:0] aluc,
                               input logic [3:0] flg);
    exp_t r;
    r.st = st; r.pcw = pcw; r.memw = memw; r.regw = regw; r.irw = irw; r.adr = adr;
    r.srca = srca; r.srcb = srcb; r.res = res; r.aluc = aluc;
    r.imm = Op; r.rsrc = {Op == 2'b01, Op == 2'b10};
    r.flg = flg;
    return r;
  endfunction

  // Condition pairs: even code tests a predicate, the following odd code its negation
  function automatic logic cond_holds(input logic [3:0] cd, input logic [3:0] f);
    logic nn, zz, cc, vv, base;
    {nn, zz, cc, vv} = f;
    case (cd[3:1])
      3'd0: base = zz;
      3'd1: base = cc;
      3'd2: base = nn;
      3'd3: base = vv;
      3'd4: base = cc && !zz;
      3'd5: base = (nn == vv);
      3'd6: base = !zz && (nn == vv);
      default: base = 1'b1;
    endcase
    return (cd == 4'hF) ? 1'b0 : (base ^ cd[0]);
  endfunction

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk or chk_ev);
      if (q.size() > 0) begin
        e = q.pop_front();
        a.st = state; a.pcw = PCWrite; a.memw = MemWrite; a.regw = RegWrite; a.irw = IRWrite;
        a.adr = AdrSrc; a.srca = ALUSrcA; a.srcb = ALUSrcB; a.res = ResultSrc;
        a.aluc = ALUControl; a.imm = ImmSrc; a.rsrc = RegSrc; a.flg = dut.flags;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t: got st=%0d vec=%h, expected st=%0d vec=%h",
                   $time, a.st, a, e.st, e);
        end
      end
    end
  end

  task automatic run_instr(input logic [3:0] cd, input logic [1:0] op,
                           input logic [5:0] fn, input logic [3:0] af);
    logic       taken, arith, s;
    logic [3:0] cmd, old_f, new_f;
    logic [1:0] aluc;
    int         len;
    Cond = cd; Op = op; Funct = fn; ALUFlags = af;
    taken = cond_holds(cd, m_flags);
    old_f = m_flags;
    cmd = fn[4:1];
    s = fn[0];
    q.push_back(rec(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, old_f));
    q.push_back(rec(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, old_f));
    case (op)
      2'b10: begin
        q.push_back(rec(4'd9, taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, old_f));
        len = 3;
      end
      2'b11: begin
        q.push_back(rec(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, old_f));
        len = 3;
      end
      2'b01: begin
        q.push_back(rec(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, old_f));
        if (fn[0]) begin
          q.push_back(rec(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, old_f));
          q.push_back(rec(4'd4, 1'b0, 1'b0, taken, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, old_f));
          len = 5;
        end else begin
          q.push_back(rec(4'd5, 1'b0, taken, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, old_f));
          len = 4;
        end
      end
      default: begin
        arith = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
        case (cmd)
          4'b0010, 4'b1010: aluc = 2'b01;
          4'b0000:          aluc = 2'b10;
          4'b1100:          aluc = 2'b11;
          default:          aluc = 2'b00;
        endcase
        new_f = old_f;
        if (taken && s && (arith || cmd == 4'b0000 || cmd == 4'b1100)) new_f[3:2] = af[3:2];
        if (taken && s && arith) new_f[1:0] = af[1:0];
        q.push_back(rec(fn[5] ? 4'd7 : 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                        fn[5] ? 2'b01 : 2'b00, 2'b00, aluc, old_f));
        q.push_back(rec(4'd8, 1'b0, 1'b0, taken && (cmd != 4'b1010), 1'b0, 1'b0, 2'b00, 2'b00,
                        2'b00, 2'b00, new_f));
        m_flags = new_f;
        len = 4;
      end
    endcase
    repeat (len) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b0; Cond = 4'h0; Op = 2'b00; Funct = 6'h0; ALUFlags = 4'h0;
    m_flags = 4'h0;
    repeat (2) q.push_back(rec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 4'h0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr(4'b1110, 2'b00, 6'b101000, 4'b1111);
    run_instr(4'b1110, 2'b00, 6'b000101, 4'b0100);
    run_instr(4'b0000, 2'b10, 6'b000000, 4'b0000);
    run_instr(4'b0001, 2'b10, 6'b000000, 4'b0000);
    run_instr(4'b1110, 2'b01, 6'b011001, 4'b0000);
    run_instr(4'b1110, 2'b01, 6'b011000, 4'b0000);
    run_instr(4'b1110, 2'b00, 6'b010101, 4'b1000);
    run_instr(4'b1110, 2'b00, 6'b000001, 4'b0111);

    for (int i = 0; i < 80; i++)
      run_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)));

    // Reset asserted while a store is in MEMWR
    run_instr(4'b1110, 2'b00, 6'b000101, 4'b1111);
    Cond = 4'b1110; Op = 2'b01; Funct = 6'b011000; ALUFlags = 4'h0;
    q.push_back(rec(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, m_flags));
    q.push_back(rec(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, m_flags));
    q.push_back(rec(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, m_flags));
    q.push_back(rec(4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, m_flags));
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    m_flags = 4'h0;
    q.push_back(rec(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 4'h0));
    #1 -> chk_ev;
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr(4'b0000, 2'b10, 6'b000000, 4'b0000);
    run_instr(4'b1110, 2'b00, 6'b100100, 4'b0110);
    run_instr(4'b1110, 2'b11, 6'b000000, 4'b0000);

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
